// File: rtl/cla_chunk_add_seq.sv
// ---------------------------------------------------------------------------
// cla_chunk_add_seq
//
// Multi-word add sequencer wrapped around one shared CHUNK_W-bit carry
// lookahead adder that lives outside this block. A TOTAL_W-bit operand pair
// (TOTAL_W = CHUNK_W * NUM_CHUNKS) is accepted via valid/ready. It is added
// one chunk per cycle, least significant chunk first, with the inter-chunk
// carry held in a register. The full sum and carry-out are then returned via
// valid/ready.
//
// Parameters
//   CHUNK_W     bits per chunk (width of the attached adder)
//   NUM_CHUNKS  chunks per operation (>= 1)
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready is high only when idle
//   in_a, in_b, in_carry  operands and carry-in of the whole add
//   out_valid/out_ready   result handshake; the result is held until taken
//   out_sum, out_carry    sum mod 2^TOTAL_W and carry-out of the MSB chunk
//   busy                  high while an operation is in flight or unread
//   add_a, add_b, add_cin to the external adder (zero outside RUN)
//   add_s, add_p, add_g   from the external adder (sum, group P, group G)
//   out_ovf               only when CLA_SEQ_OVF_EN is defined: signed
//                         two's-complement overflow, valid with out_valid
//
// Optional feature: define CLA_SEQ_OVF_EN to add the out_ovf port.
// ---------------------------------------------------------------------------
module cla_chunk_add_seq #(
    parameter int unsigned CHUNK_W    = 5,
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_b,
    input  logic                          in_carry,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] out_sum,
    output logic                          out_carry,
    output logic                          busy,
    output logic [CHUNK_W-1:0]            add_a,
    output logic [CHUNK_W-1:0]            add_b,
    output logic                          add_cin,
    input  logic [CHUNK_W-1:0]            add_s,
    input  logic                          add_p,
    input  logic                          add_g
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic                          out_ovf
`endif
);

    localparam int unsigned TOTAL_W = CHUNK_W * NUM_CHUNKS;
    // A single-chunk build still needs a 1-bit index.
    localparam int unsigned IDX_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [TOTAL_W-1:0] a_q,     a_d;
    logic [TOTAL_W-1:0] b_q,     b_d;
    logic [TOTAL_W-1:0] sum_q,   sum_d;
    logic               carry_q, carry_d;

    logic               st_idle;
    logic               st_run;
    logic               st_done;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [TOTAL_W-1:0] sum_merged;

    assign st_idle = (state_q == StIdle);
    assign st_run  = (state_q == StRun);
    assign st_done = (state_q == StDone);

    // Chunk select and sum write-back, decoded by comparing the index against
    // each chunk position. This keeps every slice constant-width.
    always_comb begin
        a_chunk    = '0;
        b_chunk    = '0;
        sum_merged = sum_q;
        for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk                          = a_q[i*CHUNK_W +: CHUNK_W];
                b_chunk                          = b_q[i*CHUNK_W +: CHUNK_W];
                sum_merged[i*CHUNK_W +: CHUNK_W] = add_s;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_carry;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = sum_merged;
                // The adder's propagate is OR-based. It can be high together
                // with generate, so the chunk carry-out is G | (P & cin).
                carry_d = add_g | (add_p & carry_q);
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxOne;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Outputs
    assign in_ready  = st_idle;
    assign busy      = st_run | st_done;
    assign out_valid = st_done;

    // Result outputs read zero unless a result is being offered.
    assign out_sum   = st_done ? sum_q : '0;
    assign out_carry = st_done & carry_q;

    assign add_a     = st_run ? a_chunk : '0;
    assign add_b     = st_run ? b_chunk : '0;
    assign add_cin   = st_run & carry_q;

`ifdef CLA_SEQ_OVF_EN
    logic carry_into_msb;

    // The carry into the MSB is recovered from the MSB's own sum bit.
    // Overflow occurs when it differs from the carry out of the MSB.
    assign carry_into_msb = a_q[TOTAL_W-1] ^ b_q[TOTAL_W-1] ^ sum_q[TOTAL_W-1];
    assign out_ovf        = st_done & (carry_into_msb ^ carry_q);
`endif

endmodule

// File: tb/tb_cla_chunk_add_seq.sv
module tb_cla_chunk_add_seq;

    localparam int unsigned CW = 5;
    localparam int unsigned NC = 4;
    localparam int unsigned TW = CW * NC;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_a;
    logic [TW-1:0] in_b;
    logic          in_carry;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_sum;
    logic          out_carry;
    logic          busy;
    logic [CW-1:0] add_a;
    logic [CW-1:0] add_b;
    logic          add_cin;
    logic [CW-1:0] add_s;
    logic          add_p;
    logic          add_g;
`ifdef CLA_SEQ_OVF_EN
    logic          out_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cla_chunk_add_seq #(
        .CHUNK_W   (CW),
        .NUM_CHUNKS(NC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_carry (in_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_p    (add_p),
        .add_g    (add_g)
`ifdef CLA_SEQ_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    // Behavioural stand-in for the external CLA chunk adder
    logic [CW:0] ab_sum;
    logic [CW:0] abc_sum;
    assign ab_sum  = {1'b0, add_a} + {1'b0, add_b};
    assign abc_sum = ab_sum + {{CW{1'b0}}, add_cin};
    assign add_s   = abc_sum[CW-1:0];
    assign add_g   = ab_sum[CW];
    assign add_p   = &(add_a | add_b);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] chunk_of(input logic [TW-1:0] v, input int i);
        logic [TW-1:0] sh;
        sh = v >> (i * CW);
        return sh[CW-1:0];
    endfunction

    // One complete transaction: accept, NC run cycles, DONE held for `hold` extra
    // cycles, then the output handshake. With `noise` set, requests and out_ready
    // are toggled randomly while busy and must have no effect.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                          input int hold, input bit noise);
        logic [TW:0] full;
        full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};

        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        @(posedge clock); #1;
        in_valid = 1'b0;

        for (int i = 0; i < int'(NC); i++) begin
            check("run_out_valid", out_valid, 0);
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            check("run_add_a", add_a, chunk_of(a, i));
            check("run_add_b", add_b, chunk_of(b, i));
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = TW'($urandom);
                in_b      = TW'($urandom);
                in_carry  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", out_valid, 1);
            check("done_out_sum", out_sum, full[TW-1:0]);
            check("done_out_carry", out_carry, full[TW]);
            check("done_in_ready", in_ready, 0);
            check("done_add_a", add_a, 0);
`ifdef CLA_SEQ_OVF_EN
            check("done_out_ovf", out_ovf,
                  (a[TW-1] == b[TW-1]) && (full[TW-1] != a[TW-1]));
`endif
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = TW'($urandom);
            end
            if (h == hold) out_ready = 1'b1;
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_out_sum", out_sum, 0);
`ifdef CLA_SEQ_OVF_EN
        check("post_out_ovf", out_ovf, 0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_cin", add_cin, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Out_ready high while nothing is offered has no effect
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);

        // Directed cases
        run_op(20'h00001, 20'h00001, 1'b0, 0, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 0, 1'b0);
        run_op(20'hFFFFF, 20'hFFFFF, 1'b1, 0, 1'b0);
        run_op(20'h00000, 20'h00000, 1'b1, 0, 1'b0);
        run_op(20'h12345, 20'h0ABCD, 1'b0, 3, 1'b0);
        run_op(20'h7FFFF, 20'h00001, 1'b0, 0, 1'b0);
        run_op(20'h80000, 20'h7FFFF, 1'b0, 1, 1'b0);

        // Reset during RUN with idx at 2
        in_valid = 1'b1;
        in_a     = 20'hABCDE;
        in_b     = 20'h13579;
        in_carry = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("mid_add_a_chunk2", add_a, chunk_of(20'hABCDE, 2));
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_add_a", add_a, 0);
        check("arst_add_b", add_b, 0);
        check("arst_add_cin", add_cin, 0);
        check("arst_out_carry", out_carry, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_op(20'h12345, 20'h0ABCD, 1'b0, 0, 1'b0);

        // Randomized operations with noise on the inputs while busy
        for (int k = 0; k < 24; k++) begin
            run_op(TW'($urandom), TW'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
